// File: rtl/module_corrector_if.sv
// Stream bundle between the channel receiver, the SECDED corrector and the
// downstream decoder. The corrector sits on the slave side; whoever feeds
// received words and consumes corrected words uses the master side.
interface module_corrector_if;
    logic [7:0] datos_rx;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] datos_corr;
    logic [2:0] sindrome;
    logic       err_simple;
    logic       err_doble;
    logic       out_valid;
    logic       out_ready;

    modport slave (
        input  datos_rx, in_valid, out_ready,
        output in_ready, datos_corr, sindrome, err_simple, err_doble, out_valid
    );

    modport master (
        output datos_rx, in_valid, out_ready,
        input  in_ready, datos_corr, sindrome, err_simple, err_doble, out_valid
    );
endinterface

// File: rtl/module_corrector.sv
// SECDED corrector for Hamming(8,4) words (bit i = position i, bit 0 = global
// even parity). Two-register valid/ready pipeline: stage 1 holds the received
// word, stage 2 holds the classified/corrected result that drives the outputs.
// Saturating single/double error counters tick on the output handshake.
module module_corrector #(
    parameter int ANCHO_CNT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    module_corrector_if.slave    bus,
    input  logic                 limpiar_cnt,
    output logic [ANCHO_CNT-1:0] cnt_simple,
    output logic [ANCHO_CNT-1:0] cnt_doble
);
    localparam int STAGES = 2;

    typedef struct packed {
        logic [7:0] datos;
        logic [2:0] sindrome;
        logic       err_simple;
        logic       err_doble;
    } resp_t;

    // vld_pipe[0] = stage 1 occupied, vld_pipe[1] = stage 2 (output) occupied
    logic [STAGES-1:0] vld_pipe;
    logic [7:0]        s1_word;
    resp_t             s2_q, s2_d;
    logic [2:0]        sin;
    logic              gpar;
    logic              adv2, acc_in, hs_out;

    // Handshake: only registered state and out_ready feed in_ready/out_valid
    assign hs_out       = vld_pipe[1] & bus.out_ready;
    assign adv2         = vld_pipe[0] & (~vld_pipe[1] | bus.out_ready);
    assign bus.in_ready = ~vld_pipe[0] | adv2;
    assign acc_in       = bus.in_valid & bus.in_ready;

    assign bus.out_valid  = vld_pipe[1];
    assign bus.datos_corr = s2_q.datos;
    assign bus.sindrome   = s2_q.sindrome;
    assign bus.err_simple = s2_q.err_simple;
    assign bus.err_doble  = s2_q.err_doble;

    // Syndrome, global parity and correction of the stage-1 word
    always_comb begin
        sin[0] = ^{s1_word[1], s1_word[3], s1_word[5], s1_word[7]};
        sin[1] = ^{s1_word[2], s1_word[3], s1_word[6], s1_word[7]};
        sin[2] = ^{s1_word[4], s1_word[5], s1_word[6], s1_word[7]};
        gpar   = ^s1_word;

        s2_d.datos      = s1_word;
        s2_d.sindrome   = sin;
        s2_d.err_simple = gpar;
        s2_d.err_doble  = ~gpar & (|sin);
        // Odd parity means a single error; s=0 points at bit 0 itself
        if (gpar)
            s2_d.datos = s1_word ^ (8'b1 << sin);
    end

    // Occupancy of both stages
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            if (adv2)
                vld_pipe[1] <= 1'b1;
            else if (hs_out)
                vld_pipe[1] <= 1'b0;

            if (acc_in)
                vld_pipe[0] <= 1'b1;
            else if (adv2)
                vld_pipe[0] <= 1'b0;
        end
    end

    // Stage data registers; stage 2 only loads when it is free or emptying
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_word <= '0;
            s2_q    <= '0;
        end else begin
            if (acc_in)
                s1_word <= bus.datos_rx;
            if (adv2)
                s2_q <= s2_d;
        end
    end

    // Saturating error counters; clear wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst || limpiar_cnt) begin
            cnt_simple <= '0;
            cnt_doble  <= '0;
        end else if (hs_out) begin
            if (s2_q.err_simple && !(&cnt_simple))
                cnt_simple <= cnt_simple + ANCHO_CNT'(1);
            if (s2_q.err_doble && !(&cnt_doble))
                cnt_doble <= cnt_doble + ANCHO_CNT'(1);
        end
    end
endmodule

// File: tb/tb_module_corrector.sv
// Directed bench for module_corrector: clean word, single errors in data and
// parity, double error, backpressure ordering, counter saturation/clear and
// mid-flight reset. Inputs change and outputs are sampled on the falling edge.
module tb_module_corrector;
    logic       clk = 1'b0;
    logic       rst;
    logic       limpiar_cnt;
    logic [7:0] cnt_simple, cnt_doble;
    int         errors = 0;
    int         checks = 0;

    module_corrector_if bus ();

    module_corrector #(.ANCHO_CNT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .limpiar_cnt (limpiar_cnt),
        .cnt_simple  (cnt_simple),
        .cnt_doble   (cnt_doble)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // One word through an idle pipeline with out_ready=1
    task automatic one_word(input string tag, input logic [7:0] w, input logic [7:0] corr,
                            input logic [2:0] s, input logic es, input logic ed,
                            input logic [7:0] cs, input logic [7:0] cd);
        bus.datos_rx = w;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk({tag, ".lat_ov"}, bus.out_valid, 1'b0);
        step();
        chk({tag, ".ov"},   bus.out_valid,  1'b1);
        chk({tag, ".corr"}, bus.datos_corr, corr);
        chk({tag, ".sin"},  bus.sindrome,   s);
        chk({tag, ".es"},   bus.err_simple, es);
        chk({tag, ".ed"},   bus.err_doble,  ed);
        step();
        chk({tag, ".cs"}, cnt_simple, cs);
        chk({tag, ".cd"}, cnt_doble,  cd);
    endtask

    initial begin
        logic [7:0] dec;
        rst = 1'b1;
        limpiar_cnt = 1'b0;
        bus.datos_rx = 8'h00;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        // Reset state
        chk("rst.ov",   bus.out_valid,  1'b0);
        chk("rst.ir",   bus.in_ready,   1'b1);
        chk("rst.corr", bus.datos_corr, 8'h00);
        chk("rst.sin",  bus.sindrome,   3'd0);
        chk("rst.es",   bus.err_simple, 1'b0);
        chk("rst.ed",   bus.err_doble,  1'b0);
        chk("rst.cs",   cnt_simple,     8'd0);
        chk("rst.cd",   cnt_doble,      8'd0);

        // Clean word; data bits at positions 7,6,5,3
        bus.datos_rx = 8'hAA;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("aa.lat_ov", bus.out_valid, 1'b0);
        step();
        chk("aa.ov",   bus.out_valid,  1'b1);
        chk("aa.corr", bus.datos_corr, 8'hAA);
        chk("aa.sin",  bus.sindrome,   3'd0);
        chk("aa.es",   bus.err_simple, 1'b0);
        chk("aa.ed",   bus.err_doble,  1'b0);
        dec = bus.datos_corr;
        chk("aa.dec", {dec[7], dec[6], dec[5], dec[3]}, 4'b1011);
        step();
        chk("aa.ov_drained", bus.out_valid, 1'b0);

        one_word("8a", 8'h8A, 8'hAA, 3'd5, 1'b1, 1'b0, 8'd1, 8'd0);
        one_word("ab", 8'hAB, 8'hAA, 3'd0, 1'b1, 1'b0, 8'd2, 8'd0);
        one_word("ac", 8'hAC, 8'hAC, 3'd3, 1'b0, 1'b1, 8'd2, 8'd1);

        // Backpressure: 00, 8A, AA with out_ready low
        bus.out_ready = 1'b0;
        bus.datos_rx = 8'h00;
        bus.in_valid = 1'b1;
        chk("bp.ir0", bus.in_ready, 1'b1);
        step();
        chk("bp.ir1", bus.in_ready, 1'b1);
        bus.datos_rx = 8'h8A;
        step();
        chk("bp.ir2", bus.in_ready, 1'b0);
        bus.datos_rx = 8'hAA;
        step();
        chk("bp.hold_ir",   bus.in_ready,   1'b0);
        chk("bp.hold_ov",   bus.out_valid,  1'b1);
        chk("bp.hold_corr", bus.datos_corr, 8'h00);
        step();
        chk("bp.hold2_corr", bus.datos_corr, 8'h00);
        chk("bp.hold2_es",   bus.err_simple, 1'b0);
        bus.out_ready = 1'b1;
        #1;
        chk("bp.ir_release", bus.in_ready, 1'b1);
        step();
        bus.in_valid = 1'b0;
        chk("bp.w1_corr", bus.datos_corr, 8'hAA);
        chk("bp.w1_es",   bus.err_simple, 1'b1);
        step();
        chk("bp.w2_ov",   bus.out_valid,  1'b1);
        chk("bp.w2_corr", bus.datos_corr, 8'hAA);
        chk("bp.w2_es",   bus.err_simple, 1'b0);
        step();
        chk("bp.empty_ov", bus.out_valid, 1'b0);
        chk("bp.cs",       cnt_simple,    8'd3);

        // Clear with no handshake pending
        limpiar_cnt = 1'b1;
        step();
        limpiar_cnt = 1'b0;
        chk("clr.cs", cnt_simple, 8'd0);
        chk("clr.cd", cnt_doble,  8'd0);

        // 256 single-error words streamed back to back
        bus.datos_rx = 8'h8A;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 256; i++) step();
        bus.in_valid = 1'b0;
        step();
        step();
        step();
        chk("sat.ov", bus.out_valid, 1'b0);
        chk("sat.cs", cnt_simple,    8'd255);

        // Clear coinciding with a single-error output handshake
        bus.datos_rx = 8'h8A;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        chk("clrhs.es", bus.err_simple, 1'b1);
        limpiar_cnt = 1'b1;
        step();
        limpiar_cnt = 1'b0;
        chk("clrhs.cs", cnt_simple, 8'd0);
        one_word("after_clr", 8'h8A, 8'hAA, 3'd5, 1'b1, 1'b0, 8'd1, 8'd0);

        // Reset with two words in flight
        bus.out_ready = 1'b0;
        bus.datos_rx = 8'h00;
        bus.in_valid = 1'b1;
        step();
        bus.datos_rx = 8'hAC;
        step();
        bus.in_valid = 1'b0;
        chk("mid.ir_full", bus.in_ready, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid.ov",   bus.out_valid,  1'b0);
        chk("mid.ir",   bus.in_ready,   1'b1);
        chk("mid.corr", bus.datos_corr, 8'h00);
        chk("mid.cs",   cnt_simple,     8'd0);
        chk("mid.cd",   cnt_doble,      8'd0);
        bus.out_ready = 1'b1;
        step();
        chk("mid.ov_after", bus.out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
